tx_burst_sequencer: RTL and testbench
=====================================

TX_BURST_SEQUENCER -- requirements
Module: tx_burst_sequencer

Interface
REQ-001 Parameter GAP_CYCLES, default 4, idle cycles inserted between consecutive bursts (range 0..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, maximum tx_ready wait before abort; used only with TSEQ_TIMEOUT_EN.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 Twrite  in  1  config write strobe, sampled each cycle.
REQ-006 Taddr  in  4  config address: 1=size, 2=burst, 3=control.
REQ-007 Tdata  in  8  config write data.
REQ-008 src_valid / src_data  in  1 / 8  byte source handshake and payload.
REQ-009 src_ready  out  1  sequencer accepts a source byte this cycle.
REQ-010 tx_valid / tx_data  out  1 / 8  byte offered to the I2C transmitter.
REQ-011 tx_ready  in  1  transmitter accepts tx_data this cycle.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse on normal completion.
REQ-014 err  out  1  sticky timeout flag, cleared by the next accepted start.
REQ-015 bytes_left / bursts_left  out  8 / 8  live remaining counts.

Function
REQ-016 Registers size_q and burst_q SHALL load Tdata when Twrite=1 with Taddr=1 or 2 respectively, only while busy=0; writes while busy SHALL be ignored.
REQ-017 Control write (Taddr=3, Twrite=1): Tdata[0]=start, Tdata[1]=abort; other bits ignored.
REQ-018 States: IDLE, FETCH, SEND, GAP, FIN.
REQ-019 IDLE: start SHALL load bytes_left=size_q, bursts_left=burst_q; if either is 0, go to FIN, else to FETCH; start while busy SHALL be ignored.
REQ-020 FETCH: src_ready=1; on src_valid=1 capture src_data into tx_data, go to SEND next cycle.
REQ-021 SEND: tx_valid=1, tx_data stable until tx_ready=1; on the accept cycle bytes_left decrements.
REQ-022 After accept, if bytes_left was >1, go to FETCH.
REQ-023 If bytes_left was 1 and bursts_left >1: bursts_left decrements, bytes_left reloads size_q, go to GAP.
REQ-024 If bytes_left was 1 and bursts_left was 1: bursts_left becomes 0, go to FIN.
REQ-025 GAP SHALL hold exactly GAP_CYCLES cycles with tx_valid=0 and src_ready=0, then go to FETCH; GAP_CYCLES=0 SHALL go directly to FETCH.
REQ-026 FIN SHALL assert done for exactly one cycle, then go to IDLE.
REQ-027 Minimum latency: start accepted in cycle N SHALL give src_ready=1 in N+1, and tx_valid=1 one cycle after the source byte is captured.
REQ-028 Abort in any state SHALL go to IDLE next cycle with tx_valid=0, src_ready=0, no done pulse, and counts frozen.
REQ-029 Start and abort in the same write: abort SHALL win.
REQ-030 tx_valid and src_ready SHALL never be high in the same cycle.
REQ-031 Total bytes per run SHALL equal size_q*burst_q (max 255*255); counters SHALL never wrap below 0.

Reset
REQ-032 rst=1 SHALL force IDLE next edge, overriding any in-flight transfer or abort.
REQ-033 Reset values: size_q=0, burst_q=0, bytes_left=0, bursts_left=0, tx_data=0, tx_valid=0, src_ready=0, busy=0, done=0, err=0, gap counter=0, timeout counter=0.

Configuration
REQ-034 Macro TSEQ_TIMEOUT_EN defined: a counter SHALL run while in SEND with tx_ready=0, reset on each accept.
REQ-035 With TSEQ_TIMEOUT_EN, reaching TIMEOUT_CYCLES SHALL set err=1, go to IDLE with no done pulse, and drop tx_valid.
REQ-036 Macro TSEQ_TIMEOUT_EN undefined: SEND SHALL wait indefinitely, err SHALL be tied 0, and no timeout counter SHALL be built.

Verification
REQ-037 size=3, burst=2, GAP_CYCLES=4, source always valid, tx_ready always 1 -> 6 bytes out in order, exactly 4 idle cycles between bytes 3 and 4, one done pulse.
REQ-038 size=0, burst=5, start -> FIN next cycle, done pulse, zero src_ready/tx_valid cycles.
REQ-039 size=2, burst=1, tx_ready held 0 for 10 cycles -> tx_valid and tx_data stable for all 10 cycles, bytes_left stays 2 until the accept.
REQ-040 Abort mid-burst after 1 of 4 bytes -> IDLE next cycle, bytes_left=3, no done; a size write then takes effect.
REQ-041 Size write of 7 while busy with size=2 -> ignored; the run sends 2 bytes per burst and size_q reads back 2.
REQ-042 TSEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, tx_ready stuck 0 -> err=1 after 16 SEND cycles, IDLE, no done; the next start clears err.

Source files
------------

// File: rtl/tx_burst_sequencer.sv
// tx_burst_sequencer: fetches bytes from a source handshake and offers them to
// a byte transmitter in bursts of size_q bytes, burst_q bursts per run, with
// GAP_CYCLES idle cycles between bursts.
// Optional build macro TSEQ_TIMEOUT_EN: abort a stalled SEND after
// TIMEOUT_CYCLES cycles without tx_ready and raise the sticky err flag.
//
// state | meaning
// IDLE  | waiting for start; size/burst registers writable
// FETCH | src_ready high, waiting for a source byte
// SEND  | tx_valid high, holding tx_data until tx_ready
// GAP   | inter-burst idle, counting down GAP_CYCLES
// FIN   | one-cycle done pulse, then back to IDLE
module tx_burst_sequencer #(
   parameter int unsigned GAP_CYCLES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Twrite,
   input  logic [3:0] Taddr,
   input  logic [7:0] Tdata,
   input  logic       src_valid,
   input  logic [7:0] src_data,
   output logic       src_ready,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   input  logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] bytes_left,
   output logic [7:0] bursts_left
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_SEND  = 3'd2,
      ST_GAP   = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

   // Gap timer is a down-counter loaded with GAP_CYCLES-1; terminal count is 0.
   localparam logic [7:0] GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

   if (GAP_CYCLES > 255 || TIMEOUT_CYCLES == 0) begin : g_param_check
      $error("tx_burst_sequencer: GAP_CYCLES must be 0..255 and TIMEOUT_CYCLES nonzero");
   end

   state_t     state_q, state_d;
   logic [7:0] size_q, size_d;
   logic [7:0] burst_q, burst_d;
   logic [7:0] bytes_q, bytes_d;
   logic [7:0] bursts_q, bursts_d;
   logic [7:0] data_q, data_d;
   logic [7:0] gap_q, gap_d;

   logic ctrl_wr, start_w, abort_w;

`ifdef TSEQ_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Abort wins over start when both bits arrive in one control write.
   assign ctrl_wr = Twrite && (Taddr == 4'd3);
   assign abort_w = ctrl_wr && Tdata[1];
   assign start_w = ctrl_wr && Tdata[0] && !Tdata[1];

   // Handshake outputs are withdrawn in the abort/reset cycle so no byte moves
   // on a cycle whose effect is discarded.
   assign src_ready   = (state_q == ST_FETCH) && !abort_w && !rst;
   assign tx_valid    = (state_q == ST_SEND) && !abort_w && !rst;
   assign tx_data     = data_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_FIN);
   assign bytes_left  = bytes_q;
   assign bursts_left = bursts_q;

   // Next-state, counter and configuration logic.
   always_comb begin
      state_d  = state_q;
      size_d   = size_q;
      burst_d  = burst_q;
      bytes_d  = bytes_q;
      bursts_d = bursts_q;
      data_d   = data_q;
      gap_d    = gap_q;
`ifdef TSEQ_TIMEOUT_EN
      err_d    = err_q;
      tmo_d    = TMO_LOAD;
`endif
      if (abort_w) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (Twrite && (Taddr == 4'd1)) size_d = Tdata;
               if (Twrite && (Taddr == 4'd2)) burst_d = Tdata;
               if (start_w) begin
                  bytes_d  = size_q;
                  bursts_d = burst_q;
`ifdef TSEQ_TIMEOUT_EN
                  err_d    = 1'b0;
`endif
                  state_d  = (size_q == 8'd0 || burst_q == 8'd0) ? ST_FIN : ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (src_valid) begin
                  data_d  = src_data;
                  state_d = ST_SEND;
               end
            end
            ST_SEND: begin
               if (tx_ready) begin
                  if (bytes_q > 8'd1) begin
                     bytes_d = bytes_q - 8'd1;
                     state_d = ST_FETCH;
                  end else if (bursts_q > 8'd1) begin
                     bursts_d = bursts_q - 8'd1;
                     bytes_d  = size_q;
                     gap_d    = GAP_LOAD;
                     state_d  = (GAP_CYCLES == 0) ? ST_FETCH : ST_GAP;
                  end else begin
                     bytes_d  = 8'd0;
                     bursts_d = 8'd0;
                     state_d  = ST_FIN;
                  end
               end
`ifdef TSEQ_TIMEOUT_EN
               else if (tmo_q == '0) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  tmo_d = tmo_q - 1'b1;
               end
`endif
            end
            ST_GAP: begin
               if (gap_q == 8'd0) state_d = ST_FETCH;
               else               gap_d   = gap_q - 8'd1;
            end
            ST_FIN: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         size_q   <= 8'd0;
         burst_q  <= 8'd0;
         bytes_q  <= 8'd0;
         bursts_q <= 8'd0;
         data_q   <= 8'd0;
         gap_q    <= 8'd0;
`ifdef TSEQ_TIMEOUT_EN
         err_q    <= 1'b0;
         tmo_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         size_q   <= size_d;
         burst_q  <= burst_d;
         bytes_q  <= bytes_d;
         bursts_q <= bursts_d;
         data_q   <= data_d;
         gap_q    <= gap_d;
`ifdef TSEQ_TIMEOUT_EN
         err_q    <= err_d;
         tmo_q    <= tmo_d;
`endif
      end
   end

endmodule

// File: tb/tb_tx_burst_sequencer.sv
// Bench for tx_burst_sequencer: directed scenarios plus randomized runs,
// all outputs compared every cycle against a transaction-level model that
// tracks bytes moved, counts remaining and the cycle each fetch is due.
module tb_tx_burst_sequencer;
   localparam int G  = 4;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst, Twrite, src_valid, tx_ready;
   logic [3:0] Taddr;
   logic [7:0] Tdata, src_data;
   logic       src_ready, tx_valid, busy, done, err;
   logic [7:0] tx_data, bytes_left, bursts_left;

   always #5 clk = ~clk;

   tx_burst_sequencer #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .Twrite(Twrite), .Taddr(Taddr), .Tdata(Tdata),
      .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .busy(busy), .done(done), .err(err),
      .bytes_left(bytes_left), .bursts_left(bursts_left)
   );

   int vectors = 0;
   int miscompares = 0;
   longint cyc = 0;

   // model state
   bit         m_valid, m_active, m_fin, m_have, m_err;
   int         m_size, m_burst, m_S, m_B, m_k, m_bl, m_bul, m_stall;
   logic [7:0] m_byte;
   longint     m_fetch_at;

   // observed statistics for literal checks
   int obs_bytes, obs_done, obs_idle, obs_src, obs_txv;

   // stimulus policy (percent)
   int p_src = 100, p_rdy = 100, p_wr = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic clear_stats();
      obs_bytes = 0; obs_done = 0; obs_idle = 0; obs_src = 0; obs_txv = 0;
   endtask

   task automatic model_reset();
      m_active = 0; m_fin = 0; m_have = 0; m_err = 0;
      m_size = 0; m_burst = 0; m_S = 0; m_B = 0; m_k = 0;
      m_bl = 0; m_bul = 0; m_stall = 0; m_byte = 8'd0; m_fetch_at = 0;
   endtask

   // Compare outputs mid-cycle, then advance the model with this cycle's inputs.
   task automatic cycle_check();
      bit abort_w, start_w, e_src, e_tx;
      @(negedge clk);
      abort_w = Twrite && Taddr == 4'd3 && Tdata[1];
      start_w = Twrite && Taddr == 4'd3 && Tdata[0] && !abort_w;
      e_src = !rst && !abort_w && m_active && !m_fin && !m_have && (cyc >= m_fetch_at);
      e_tx  = !rst && !abort_w && m_active && m_have;
      if (m_valid && !rst) begin
         chk("src_ready", src_ready, e_src);
         chk("tx_valid", tx_valid, e_tx);
         chk("tx_data", tx_data, m_byte);
         chk("busy", busy, m_active);
         chk("done", done, m_fin);
         chk("err", err, m_err);
         chk("bytes_left", bytes_left, m_bl);
         chk("bursts_left", bursts_left, m_bul);
         chk("ready_valid_excl", src_ready && tx_valid, 0);
      end
      if (tx_valid && tx_ready) obs_bytes++;
      if (done) obs_done++;
      if (src_ready) obs_src++;
      if (tx_valid) obs_txv++;
      if (busy && !src_ready && !tx_valid && !done) obs_idle++;

      if (rst) begin
         model_reset();
      end else if (abort_w) begin
         m_active = 0; m_have = 0; m_fin = 0; m_stall = 0;
      end else if (m_fin) begin
         m_fin = 0; m_active = 0;
      end else if (!m_active) begin
         if (Twrite && Taddr == 4'd1) m_size = Tdata;
         if (Twrite && Taddr == 4'd2) m_burst = Tdata;
         if (start_w) begin
`ifdef TSEQ_TIMEOUT_EN
            m_err = 0;
`endif
            m_S = m_size; m_B = m_burst; m_k = 0;
            m_bl = m_S; m_bul = m_B;
            m_active = 1; m_have = 0; m_stall = 0;
            if (m_S == 0 || m_B == 0) m_fin = 1;
            else m_fetch_at = cyc + 1;
         end
      end else if (e_tx) begin
         if (tx_ready) begin
            m_k++; m_have = 0; m_stall = 0;
            if (m_k == m_S * m_B) begin
               m_bl = 0; m_bul = 0; m_fin = 1;
            end else begin
               m_bul = m_B - m_k / m_S;
               m_bl  = m_S - m_k % m_S;
               m_fetch_at = (m_k % m_S == 0) ? cyc + 1 + G : cyc + 1;
            end
         end else begin
            m_stall++;
`ifdef TSEQ_TIMEOUT_EN
            if (m_stall == TO) begin
               m_err = 1; m_active = 0; m_have = 0; m_stall = 0;
            end
`endif
         end
      end else if (e_src && src_valid) begin
         m_have = 1; m_byte = src_data;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic step();
      src_valid = ($urandom_range(99) < p_src);
      src_data  = 8'($urandom);
      tx_ready  = ($urandom_range(99) < p_rdy);
      cycle_check();
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      Twrite = 1'b1; Taddr = a; Tdata = d;
      step();
      Twrite = 1'b0;
   endtask

   task automatic rand_step();
      int r;
      r = $urandom_range(99);
      if (r < p_wr) begin
         Twrite = 1'b1;
         Taddr  = 4'($urandom_range(3, 1));
         Tdata  = 8'($urandom);
         if (Taddr == 4'd3 && Tdata[1] && $urandom_range(1) == 0) Tdata[1] = 1'b0;
      end
      step();
      Twrite = 1'b0;
   endtask

   task automatic run_until_idle(input int budget);
      int n = 0;
      while (m_active && n < budget) begin
         rand_step();
         n++;
      end
      chk("run_completes", m_active, 0);
   endtask

   initial begin
      rst = 1'b1; Twrite = 1'b0; Taddr = 4'd0; Tdata = 8'd0;
      src_valid = 1'b0; src_data = 8'd0; tx_ready = 1'b0;
      m_valid = 0;
      model_reset();
      clear_stats();
      step();
      step();
      rst = 1'b0;
      m_valid = 1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_src_ready", src_ready, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_bytes_left", bytes_left, 0);
      chk("rst_bursts_left", bursts_left, 0);

      // size 3, burst 2, everything always ready
      p_src = 100; p_rdy = 100; p_wr = 0;
      wr(4'd1, 8'd3); wr(4'd2, 8'd2);
      clear_stats();
      wr(4'd3, 8'h01);
      run_until_idle(200);
      chk("basic_bytes", obs_bytes, 6);
      chk("basic_gap_idle", obs_idle, 4);
      chk("basic_done", obs_done, 1);

      // zero size: straight to FIN
      wr(4'd1, 8'd0); wr(4'd2, 8'd5);
      clear_stats();
      wr(4'd3, 8'h01);
      step();
      chk("zero_done_next", obs_done, 1);
      run_until_idle(20);
      chk("zero_src_ready", obs_src, 0);
      chk("zero_tx_valid", obs_txv, 0);

      // tx_ready held low for 10 cycles
      wr(4'd1, 8'd2); wr(4'd2, 8'd1);
      p_rdy = 0;
      wr(4'd3, 8'h01);
      step();
      for (int i = 0; i < 10; i++) step();
      chk("stall_bytes_left", bytes_left, 2);
      chk("stall_tx_valid", tx_valid, 1);
      p_rdy = 100;
      run_until_idle(50);

      // abort after 1 of 4 bytes
      wr(4'd1, 8'd4); wr(4'd2, 8'd2);
      clear_stats();
      wr(4'd3, 8'h01);
      step();
      step();
      wr(4'd3, 8'h03);
      chk("abort_busy", busy, 0);
      chk("abort_bytes_left", bytes_left, 3);
      chk("abort_no_done", obs_done, 0);
      wr(4'd1, 8'd5); wr(4'd2, 8'd1);
      wr(4'd3, 8'h01);
      chk("after_abort_size", bytes_left, 5);
      run_until_idle(100);

      // size write while busy is ignored
      wr(4'd1, 8'd2); wr(4'd2, 8'd2);
      clear_stats();
      wr(4'd3, 8'h01);
      step();
      wr(4'd1, 8'd7);
      run_until_idle(100);
      chk("busy_write_bytes", obs_bytes, 4);
      wr(4'd2, 8'd1);
      wr(4'd3, 8'h01);
      chk("busy_write_size", bytes_left, 2);
      run_until_idle(50);

`ifdef TSEQ_TIMEOUT_EN
      wr(4'd1, 8'd1); wr(4'd2, 8'd1);
      p_rdy = 0;
      clear_stats();
      wr(4'd3, 8'h01);
      run_until_idle(100);
      chk("tmo_err", err, 1);
      chk("tmo_busy", busy, 0);
      chk("tmo_no_done", obs_done, 0);
      chk("tmo_send_cycles", obs_txv, TO);
      p_rdy = 100;
      wr(4'd3, 8'h01);
      chk("tmo_err_cleared", err, 0);
      run_until_idle(50);
`else
      wr(4'd1, 8'd1); wr(4'd2, 8'd1);
      p_rdy = 0;
      wr(4'd3, 8'h01);
      for (int i = 0; i < 100; i++) step();
      chk("nowait_busy", busy, 1);
      chk("nowait_err", err, 0);
      wr(4'd3, 8'h02);
      chk("nowait_abort", busy, 0);
      p_rdy = 100;
`endif

      // randomized runs
      for (int r = 0; r < 40; r++) begin
         p_src = int'($urandom_range(100, 30));
         p_rdy = int'($urandom_range(100, 30));
         p_wr  = 0;
         wr(4'd1, 8'($urandom_range(5)));
         wr(4'd2, 8'($urandom_range(3)));
         wr(4'd3, 8'h01);
         p_wr = 4;
         run_until_idle(2000);
         p_wr = 0;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
